instruction_aligner: RTL and testbench

INSTRUCTION_ALIGNER -- requirements
Module: instruction_aligner

---
 rtl/instruction_aligner.sv | 112 +++++++++++
 tb/tb_instruction_aligner.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_aligner.sv
// Realigns a stream of 32-bit little-endian fetch words into whole RISC-V instructions,
// handling 16-bit compressed encodings and 32-bit instructions that straddle two words.
module instruction_aligner #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       in_word,
    output logic              in_ready,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic              out_valid,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_compressed,
    input  logic              out_ready
);

    logic [15:0]       hw_q [3];
    logic [15:0]       hw_d [3];
    logic [1:0]        count_q, count_d;
    logic [ADDR_W-1:0] head_pc_q, head_pc_d;
    logic              skip_low_q, skip_low_d;

    logic              head_compressed;
    logic [1:0]        head_size;
    logic [1:0]        pop_size;
    logic [1:0]        push_size;
    logic [1:0]        wr_idx;
    logic              pop;
    logic              push;
    logic              flush_lsb_unused;

    assign flush_lsb_unused = flush_pc[0];

    assign head_compressed = (hw_q[0][1:0] != 2'b11);
    assign head_size       = head_compressed ? 2'd1 : 2'd2;

    assign out_valid      = !flush && (count_q >= head_size);
    assign in_ready       = !flush && (count_q <= 2'd1);
    assign out_instr      = head_compressed ? {16'h0000, hw_q[0]} : {hw_q[1], hw_q[0]};
    assign out_pc         = head_pc_q;
    // An empty FIFO holds stale data, so it never reports a compressed head.
    assign out_compressed = (count_q != 2'd0) && head_compressed;

    assign pop       = out_valid && out_ready;
    assign push      = in_valid && in_ready;
    assign pop_size  = pop ? head_size : 2'd0;
    assign push_size = !push ? 2'd0 : (skip_low_q ? 2'd1 : 2'd2);
    // in_ready guarantees count <= 1 on a push, so appended halfwords land at index <= 2.
    assign wr_idx    = count_q - pop_size;

    always_comb begin
        hw_d       = hw_q;
        count_d    = count_q;
        head_pc_d  = head_pc_q;
        skip_low_d = skip_low_q;

        if (flush) begin
            count_d    = 2'd0;
            head_pc_d  = {flush_pc[ADDR_W-1:1], 1'b0};
            skip_low_d = flush_pc[1];
        end else begin
            case (pop_size)
                2'd1: begin
                    hw_d[0] = hw_q[1];
                    hw_d[1] = hw_q[2];
                end
                2'd2: begin
                    hw_d[0] = hw_q[2];
                end
                default: begin
                end
            endcase

            if (push) begin
                if (skip_low_q) begin
                    hw_d[wr_idx] = in_word[31:16];
                    skip_low_d   = 1'b0;
                end else begin
                    hw_d[wr_idx]         = in_word[15:0];
                    hw_d[wr_idx + 2'd1]  = in_word[31:16];
                end
            end

            count_d = count_q - pop_size + push_size;

            if (pop) begin
                head_pc_d = head_pc_q + ADDR_W'(head_compressed ? 3'd2 : 3'd4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= 2'd0;
            head_pc_q  <= '0;
            skip_low_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            head_pc_q  <= head_pc_d;
            skip_low_q <= skip_low_d;
        end
    end

    // Halfword storage carries no control meaning, so it is left out of reset.
    always_ff @(posedge clk) begin
        hw_q <= hw_d;
    end

endmodule

// File: tb/tb_instruction_aligner.sv
// Bench for instruction_aligner: halfword-queue reference model checked every cycle,
// plus literal expectations of the retired instruction stream per scenario.
module tb_instruction_aligner;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_word;
    logic        in_ready;
    logic        flush;
    logic [31:0] flush_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_compressed;
    logic        out_ready;

    int tests;
    int failed;

    instruction_aligner #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_word(in_word), .in_ready(in_ready),
        .flush(flush), .flush_pc(flush_pc),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_compressed(out_compressed), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain queue of halfwords in program order.
    logic [15:0] mq[$];
    logic [31:0] mpc;
    bit          mskip;

    logic [31:0] dut_i[$], dut_p[$], mdl_i[$], mdl_p[$];
    bit          dut_c[$], mdl_c[$];

    function automatic int m_need();
        if (mq.size() > 0 && mq[0][1:0] == 2'b11) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] m_instr();
        if (m_need() == 1) return {16'h0000, mq[0]};
        return {mq[1], mq[0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        failed++;
        $display("FAIL %s: got nothing, expected an entry", name);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit ev;
        bit er;
        if (!rst) begin
            ev = !flush && (mq.size() >= m_need());
            er = !flush && (mq.size() <= 1);
            chk("cyc_out_valid", out_valid, ev);
            chk("cyc_in_ready", in_ready, er);
            chk("cyc_out_pc", out_pc, mpc);
            if (ev) begin
                chk("cyc_out_instr", out_instr, m_instr());
                chk("cyc_out_compressed", out_compressed, m_need() == 1);
            end
            if (out_valid && out_ready) begin
                dut_i.push_back(out_instr);
                dut_p.push_back(out_pc);
                dut_c.push_back(out_compressed);
            end
        end
    end

    always @(posedge clk) begin
        int  sz;
        bit  v;
        bit  r;
        if (rst) begin
            mq.delete();
            mpc   = 32'h0;
            mskip = 1'b0;
        end else if (flush) begin
            mq.delete();
            mpc   = {flush_pc[31:1], 1'b0};
            mskip = flush_pc[1];
        end else begin
            sz = m_need();
            v  = mq.size() >= sz;
            r  = mq.size() <= 1;
            if (v && out_ready) begin
                mdl_i.push_back(m_instr());
                mdl_p.push_back(mpc);
                mdl_c.push_back(sz == 1);
                for (int k = 0; k < sz; k++) void'(mq.pop_front());
                mpc = mpc + 32'(sz * 2);
            end
            if (in_valid && r) begin
                if (mskip) begin
                    mq.push_back(in_word[31:16]);
                    mskip = 1'b0;
                end else begin
                    mq.push_back(in_word[15:0]);
                    mq.push_back(in_word[31:16]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_logs();
        dut_i.delete(); dut_p.delete(); dut_c.delete();
        mdl_i.delete(); mdl_p.delete(); mdl_c.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        clear_logs();
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_compressed", out_compressed, 1'b0);
    endtask

    task automatic push(input logic [31:0] w);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_word = w;
        #1;
        for (int k = 0; k < 20 && !done; k++) begin
            if (in_ready) done = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (!done) fail_now("push_timeout");
    endtask

    task automatic chk_pop(input int idx, input logic [31:0] i, input logic [31:0] p, input bit c);
        if (idx < dut_i.size()) begin
            chk("dut_pop_instr", dut_i[idx], i);
            chk("dut_pop_pc", dut_p[idx], p);
            chk("dut_pop_compressed", dut_c[idx], c);
        end else fail_now("dut_pop_missing");
        if (idx < mdl_i.size()) begin
            chk("mdl_pop_instr", mdl_i[idx], i);
            chk("mdl_pop_pc", mdl_p[idx], p);
            chk("mdl_pop_compressed", mdl_c[idx], c);
        end else fail_now("mdl_pop_missing");
    endtask

    initial begin
        tests = 0;
        failed = 0;
        rst = 1'b1; in_valid = 1'b0; in_word = 32'h0;
        flush = 1'b0; flush_pc = 32'h0; out_ready = 1'b1;

        // single 32-bit instruction, one-cycle latency
        do_reset();
        push(32'h00130313);
        chk("lat_out_valid", out_valid, 1'b1);
        chk("lat_out_instr", out_instr, 32'h00130313);
        chk("lat_out_pc", out_pc, 32'h0);
        chk("lat_out_compressed", out_compressed, 1'b0);
        idle(3);
        chk("s1_pops", dut_i.size(), 1);
        chk_pop(0, 32'h00130313, 32'h0, 1'b0);

        // two compressed in one word
        do_reset();
        push(32'h45014581);
        idle(4);
        chk("s2_pops", dut_i.size(), 2);
        chk_pop(0, 32'h00004581, 32'h0, 1'b1);
        chk_pop(1, 32'h00004501, 32'h2, 1'b1);

        // 32-bit instruction straddling two words
        do_reset();
        push(32'h03134581);
        chk("s3_first_instr", out_instr, 32'h00004581);
        tick();
        chk("s3_straddle_hold", out_valid, 1'b0);
        push(32'h45010013);
        chk("s3_joined_valid", out_valid, 1'b1);
        chk("s3_joined_instr", out_instr, 32'h00130313);
        idle(4);
        chk("s3_pops", dut_i.size(), 3);
        chk_pop(0, 32'h00004581, 32'h0, 1'b1);
        chk_pop(1, 32'h00130313, 32'h2, 1'b0);
        chk_pop(2, 32'h00004501, 32'h6, 1'b1);

        // flush to odd halfword, word offered during flush is refused
        do_reset();
        flush = 1'b1; flush_pc = 32'h102; in_valid = 1'b1; in_word = 32'h12345678;
        #1;
        chk("s4_flush_in_ready", in_ready, 1'b0);
        tick();
        flush = 1'b0;
        push(32'h4501FFFF);
        idle(4);
        chk("s4_pops", dut_i.size(), 1);
        chk_pop(0, 32'h00004501, 32'h102, 1'b1);

        // backpressure
        do_reset();
        out_ready = 1'b0;
        push(32'h00130313);
        in_valid = 1'b1; in_word = 32'h45014581;
        repeat (3) begin
            #1;
            chk("s5_stall_valid", out_valid, 1'b1);
            chk("s5_stall_instr", out_instr, 32'h00130313);
            chk("s5_stall_pc", out_pc, 32'h0);
            chk("s5_stall_in_ready", in_ready, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        push(32'h45014581);
        push(32'h00000013);
        idle(5);
        chk("s5_pops", dut_i.size(), 4);
        chk_pop(0, 32'h00130313, 32'h0, 1'b0);
        chk_pop(1, 32'h00004581, 32'h4, 1'b1);
        chk_pop(2, 32'h00004501, 32'h6, 1'b1);
        chk_pop(3, 32'h00000013, 32'h8, 1'b0);

        // flush with three halfwords queued and the decoder stalled
        do_reset();
        out_ready = 1'b0;
        push(32'h03134581);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        push(32'h45010013);
        chk("s6_full_in_ready", in_ready, 1'b0);
        chk("s6_full_instr", out_instr, 32'h00130313);
        flush = 1'b1; flush_pc = 32'h200;
        #1;
        chk("s6_flush_valid", out_valid, 1'b0);
        tick();
        flush = 1'b0;
        #1;
        chk("s6_after_valid", out_valid, 1'b0);
        chk("s6_after_in_ready", in_ready, 1'b1);
        chk("s6_after_pc", out_pc, 32'h200);
        chk("s6_pops", dut_i.size(), 1);
        chk_pop(0, 32'h00004581, 32'h0, 1'b1);

        // head_pc wrap
        do_reset();
        out_ready = 1'b1;
        flush = 1'b1; flush_pc = 32'hFFFFFFFE;
        tick();
        flush = 1'b0;
        push(32'h45014581);
        push(32'h00130313);
        idle(4);
        chk("s7_pops", dut_i.size(), 2);
        chk_pop(0, 32'h00004501, 32'hFFFFFFFE, 1'b1);
        chk_pop(1, 32'h00130313, 32'h0, 1'b0);

        // reset beats flush and push mid-instruction
        do_reset();
        out_ready = 1'b0;
        push(32'h03134581);
        rst = 1'b1; flush = 1'b1; flush_pc = 32'h300;
        in_valid = 1'b1; in_word = 32'h11111111; out_ready = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("s8_rst_valid", out_valid, 1'b0);
        chk("s8_rst_in_ready", in_ready, 1'b1);
        chk("s8_rst_pc", out_pc, 32'h0);
        chk("s8_rst_compressed", out_compressed, 1'b0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
